// File: rtl/wb_stage.sv
// Write-back stage: waits out load latency, aligns/extends load data, selects the
// result, issues one register-file write, then pulses WB_kick_up and counts retires.
module wb_stage #(
   parameter int MEM_READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MEM_kick_up,
   input  logic [31:0] ALU_result,
   input  logic [31:0] Data_mem_read_data,
   input  logic        Controller_memread,
   input  logic        Controller_regwrite,
   input  logic        Controller_jump,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [31:0] pc_plus_4,
   output logic        Reg_write_enable,
   output logic [4:0]  Reg_write_addr,
   output logic [31:0] Reg_write_data,
   output logic        WB_kick_up,
   output logic [63:0] instret
);

   typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

   localparam logic [2:0] LAT = 3'(MEM_READ_LATENCY);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        kick_q, kick_d;
   logic [63:0] instret_q, instret_d;

   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;
   logic [31:0] result;

   always_comb begin
      load_byte = 8'h00;
      case (ALU_result[1:0])
         2'd0: load_byte = Data_mem_read_data[7:0];
         2'd1: load_byte = Data_mem_read_data[15:8];
         2'd2: load_byte = Data_mem_read_data[23:16];
         2'd3: load_byte = Data_mem_read_data[31:24];
         default: load_byte = 8'h00;
      endcase
      load_half = ALU_result[1] ? Data_mem_read_data[31:16] : Data_mem_read_data[15:0];

      // Reserved load widths fall through to a plain word load.
      case (funct3)
         3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
         3'b100:  load_data = {24'h0, load_byte};
         3'b001:  load_data = {{16{load_half[15]}}, load_half};
         3'b101:  load_data = {16'h0, load_half};
         default: load_data = Data_mem_read_data;
      endcase

      if (Controller_jump)
         result = pc_plus_4;
      else if (Controller_memread)
         result = load_data;
      else
         result = ALU_result;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      kick_d    = 1'b0;
      instret_d = instret_q;

      case (state_q)
         IDLE: begin
            if (MEM_kick_up) begin
               if (Controller_memread && (LAT != 3'd0)) begin
                  cnt_d   = LAT;
                  state_d = WAIT;
               end else begin
                  addr_d  = rd;
                  data_d  = result;
                  we_d    = Controller_regwrite && (rd != 5'd0);
                  state_d = WRITE;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            // cnt==1 marks the cycle in which read data is valid.
            if (cnt_q == 3'd1) begin
               addr_d  = rd;
               data_d  = result;
               we_d    = Controller_regwrite && (rd != 5'd0);
               state_d = WRITE;
            end
         end
         WRITE: begin
            kick_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            instret_d = instret_q + 64'd1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 3'd0;
         we_q      <= 1'b0;
         addr_q    <= 5'd0;
         data_q    <= 32'd0;
         kick_q    <= 1'b0;
         instret_q <= 64'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         kick_q    <= kick_d;
         instret_q <= instret_d;
      end
   end

   assign Reg_write_enable = we_q;
   assign Reg_write_addr   = addr_q;
   assign Reg_write_data   = data_q;
   assign WB_kick_up       = kick_q;
   assign instret          = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: three instances (latency 0, 1, 3) share stimulus; per-instance
// scoreboards hold expected writes and retires, popped when the DUT produces them.
module tb_wb_stage;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_kick = 1'b0;
   logic [31:0] alu = '0;
   logic [31:0] rdata [N];
   logic        memread = 1'b0;
   logic        regwrite = 1'b0;
   logic        jump = 1'b0;
   logic [2:0]  f3 = '0;
   logic [4:0]  rd = '0;
   logic [31:0] pc4 = '0;

   logic        we [N];
   logic [4:0]  waddr [N];
   logic [31:0] wdata [N];
   logic        kick [N];
   logic [63:0] ir [N];

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_exp_t;

   typedef struct {
      int          cyc;
      logic [63:0] ir;
      logic [4:0]  addr;
      logic [31:0] data;
   } kick_exp_t;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] rdata;
      logic        memread;
      logic        regwrite;
      logic        jump;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic [31:0] exp;
      logic        extra;
   } txn_t;

   wr_exp_t   wq [N][$];
   kick_exp_t kq [N][$];
   logic [63:0] exp_ir [N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int i);
      return (i == 0) ? 0 : (i == 1) ? 1 : 3;
   endfunction

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      wb_stage #(.MEM_READ_LATENCY((gi == 0) ? 0 : (gi == 1) ? 1 : 3)) dut (
         .clk                 (clk),
         .reset               (reset),
         .MEM_kick_up         (mem_kick),
         .ALU_result          (alu),
         .Data_mem_read_data  (rdata[gi]),
         .Controller_memread  (memread),
         .Controller_regwrite (regwrite),
         .Controller_jump     (jump),
         .funct3              (f3),
         .rd                  (rd),
         .pc_plus_4           (pc4),
         .Reg_write_enable    (we[gi]),
         .Reg_write_addr      (waddr[gi]),
         .Reg_write_data      (wdata[gi]),
         .WB_kick_up          (kick[gi]),
         .instret             (ir[gi])
      );
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   for (genvar gi = 0; gi < N; gi++) begin : g_mon
      always @(negedge clk) begin
         wr_exp_t   w;
         kick_exp_t k;
         if (we[gi]) begin
            if (wq[gi].size() == 0) begin
               check_val($sformatf("unexpected_write_L%0d", lat_of(gi)), 64'd1, 64'd0);
            end else begin
               w = wq[gi].pop_front();
               check_val($sformatf("waddr_L%0d", lat_of(gi)), 64'(waddr[gi]), 64'(w.addr));
               check_val($sformatf("wdata_L%0d", lat_of(gi)), 64'(wdata[gi]), 64'(w.data));
               check_val($sformatf("wcycle_L%0d", lat_of(gi)), 64'(cyc), 64'(w.cyc));
               $display("L%0d write x%0d=%h at cycle %0d", lat_of(gi), waddr[gi], wdata[gi], cyc);
            end
         end
         if (kick[gi]) begin
            if (kq[gi].size() == 0) begin
               check_val($sformatf("unexpected_kick_L%0d", lat_of(gi)), 64'd1, 64'd0);
            end else begin
               k = kq[gi].pop_front();
               check_val($sformatf("kcycle_L%0d", lat_of(gi)), 64'(cyc), 64'(k.cyc));
               check_val($sformatf("instret_L%0d", lat_of(gi)), ir[gi], k.ir);
               check_val($sformatf("we_in_done_L%0d", lat_of(gi)), 64'(we[gi]), 64'd0);
               check_val($sformatf("hold_addr_L%0d", lat_of(gi)), 64'(waddr[gi]), 64'(k.addr));
               check_val($sformatf("hold_data_L%0d", lat_of(gi)), 64'(wdata[gi]), 64'(k.data));
               $display("L%0d retire at cycle %0d instret=%0d", lat_of(gi), cyc, ir[gi]);
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < N; i++) begin
         check_val($sformatf("%s_we_L%0d", tag, lat_of(i)), 64'(we[i]), 64'd0);
         check_val($sformatf("%s_addr_L%0d", tag, lat_of(i)), 64'(waddr[i]), 64'd0);
         check_val($sformatf("%s_data_L%0d", tag, lat_of(i)), 64'(wdata[i]), 64'd0);
         check_val($sformatf("%s_kick_L%0d", tag, lat_of(i)), 64'(kick[i]), 64'd0);
         check_val($sformatf("%s_instret_L%0d", tag, lat_of(i)), ir[i], 64'd0);
      end
   endtask

   // Drive one instruction; each instance gets stale data until its sample cycle.
   task automatic run_txn(input txn_t t);
      int t0;
      int leff;
      @(negedge clk);
      t0 = cyc;
      for (int i = 0; i < N; i++) begin
         leff = t.memread ? lat_of(i) : 0;
         if (t.regwrite && (t.rd != 5'd0))
            wq[i].push_back('{addr: t.rd, data: t.exp, cyc: t0 + leff + 1});
         kq[i].push_back('{cyc: t0 + leff + 2, ir: exp_ir[i], addr: t.rd, data: t.exp});
         exp_ir[i] = exp_ir[i] + 64'd1;
      end
      alu = t.alu; memread = t.memread; regwrite = t.regwrite; jump = t.jump;
      f3 = t.f3; rd = t.rd; pc4 = t.pc4;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge clk);
         mem_kick = (k == 0) || (t.extra && (k == 1 || k == 2));
         for (int i = 0; i < N; i++)
            rdata[i] = (t.memread && k < lat_of(i)) ? ~t.rdata : t.rdata;
      end
      mem_kick = 1'b0;
   endtask

   txn_t tbl [13];

   initial begin
      for (int i = 0; i < N; i++) begin
         rdata[i] = '0;
         exp_ir[i] = '0;
      end
      //          alu           rdata         mr    rw    j     f3      rd     pc4       exp           extra
      tbl[0]  = '{32'h0000_1234, 32'h0,        1'b0, 1'b1, 1'b0, 3'b000, 5'd5,  32'h0,    32'h0000_1234, 1'b0};
      tbl[1]  = '{32'h0000_0103, 32'h80FF_0000, 1'b1, 1'b1, 1'b0, 3'b000, 5'd7,  32'h0,    32'hFFFF_FF80, 1'b0};
      tbl[2]  = '{32'h0000_0202, 32'h80FF_1234, 1'b1, 1'b1, 1'b0, 3'b101, 5'd8,  32'h0,    32'h0000_80FF, 1'b0};
      tbl[3]  = '{32'h0000_0200, 32'h80FF_1234, 1'b1, 1'b1, 1'b0, 3'b001, 5'd9,  32'h0,    32'h0000_1234, 1'b0};
      tbl[4]  = '{32'h0000_0201, 32'h80FF_1234, 1'b1, 1'b1, 1'b0, 3'b100, 5'd10, 32'h0,    32'h0000_0012, 1'b0};
      tbl[5]  = '{32'h0000_0303, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 3'b010, 5'd11, 32'h0,    32'hDEAD_BEEF, 1'b0};
      tbl[6]  = '{32'h0000_0403, 32'h8001_7FFF, 1'b1, 1'b1, 1'b0, 3'b001, 5'd12, 32'h0,    32'hFFFF_8001, 1'b0};
      tbl[7]  = '{32'h0000_0001, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 3'b110, 5'd13, 32'h0,    32'h1234_5678, 1'b0};
      tbl[8]  = '{32'h0000_0999, 32'h0,        1'b0, 1'b1, 1'b1, 3'b000, 5'd1,  32'h0000_0040, 32'h0000_0040, 1'b0};
      tbl[9]  = '{32'h0000_0ABC, 32'h0,        1'b0, 1'b0, 1'b0, 3'b010, 5'd3,  32'h0,    32'h0000_0ABC, 1'b0};
      tbl[10] = '{32'h0000_0DEF, 32'h0,        1'b0, 1'b1, 1'b0, 3'b000, 5'd0,  32'h0,    32'h0000_0DEF, 1'b0};
      tbl[11] = '{32'h0000_0503, 32'h80FF_1234, 1'b1, 1'b1, 1'b0, 3'b100, 5'd14, 32'h0,    32'h0000_0080, 1'b1};
      tbl[12] = '{32'h0000_0600, 32'h0000_007F, 1'b1, 1'b1, 1'b0, 3'b000, 5'd31, 32'h0,    32'h0000_007F, 1'b1};

      repeat (2) @(negedge clk);
      check_reset_state("reset");
      reset = 1'b0;

      for (int n = 0; n < 13; n++) run_txn(tbl[n]);

      // Reset while the load is in flight (L=1/L=3 in WAIT, L=0 in WRITE).
      @(negedge clk);
      alu = 32'h0000_0700; memread = 1'b1; regwrite = 1'b1; jump = 1'b0;
      f3 = 3'b010; rd = 5'd20;
      for (int i = 0; i < N; i++) rdata[i] = 32'hCAFE_F00D;
      mem_kick = 1'b1;
      @(posedge clk);
      #1 reset = 1'b1;
      mem_kick = 1'b0;
      @(negedge clk);
      check_reset_state("midreset");
      for (int i = 0; i < N; i++) exp_ir[i] = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);

      run_txn(tbl[0]);
      run_txn(tbl[1]);

      repeat (10) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check_val($sformatf("pending_writes_L%0d", lat_of(i)), 64'(wq[i].size()), 64'd0);
         check_val($sformatf("pending_kicks_L%0d", lat_of(i)), 64'(kq[i].size()), 64'd0);
         check_val($sformatf("final_instret_L%0d", lat_of(i)), ir[i], exp_ir[i]);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the single-issue RISC-V core, directly downstream of the MEM stage. It receives the MEM completion pulse, waits out data-memory read latency for loads, then aligns and extends load data, or selects the ALU result or PC+4. It issues one register-file write and pulses a completion kick to fetch, and it also counts retired instructions.

## Interface
- MEM_READ_LATENCY, 1, cycles from MEM kick until Data_mem_read_data is valid; legal 0..7
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- MEM_kick_up  in  1  one-cycle pulse: MEM stage finished; all other inputs stable from this cycle until WB_kick_up
- ALU_result  in  32  ALU result, also the load address
- Data_mem_read_data  in  32  word read from data memory at ALU_result[31:2]
- Controller_memread  in  1  instruction is a load
- Controller_regwrite  in  1  instruction writes rd
- Controller_jump  in  1  JAL/JALR: write PC+4
- funct3  in  3  load width: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rd  in  5  destination register
- pc_plus_4  in  32  link value
- Reg_write_enable  out  1  register-file write strobe
- Reg_write_addr  out  5  register-file write address
- Reg_write_data  out  32  register-file write data
- WB_kick_up  out  1  one-cycle pulse: instruction retired
- instret  out  64  retired-instruction count

## Operation
- FSM states:
  - IDLE: wait for MEM_kick_up.
  - WAIT: load latency countdown.
  - WRITE: register-file write cycle.
  - DONE: assert WB_kick_up.
- IDLE + MEM_kick_up:
  - If load and MEM_READ_LATENCY>0: load cnt=MEM_READ_LATENCY, go WAIT.
  - Otherwise: capture the result and go WRITE.
- WAIT: cnt decrements each edge. At the edge where cnt==1, capture the aligned load data and go WRITE.
- Result select, in priority order: Controller_jump → pc_plus_4; Controller_memread → load data; else ALU_result.
- Load alignment (off=ALU_result[1:0]):
  - LB/LBU: byte lane off, sign- or zero-extended to 32 bits.
  - LH/LHU: halfword ALU_result[1], sign- or zero-extended; off[0] ignored.
  - LW: full word; off ignored.
  - Undefined funct3: treated as LW.
- WRITE: Reg_write_enable=Controller_regwrite && rd!=0. Reg_write_addr=rd and Reg_write_data=captured result, both registered at the capture edge. Next state DONE.
- DONE: WB_kick_up=1 and instret increments by 1; next state IDLE.
- Reg_write_addr/data hold their last captured values outside WRITE.
- MEM_kick_up in any state other than IDLE is ignored; no queuing.
- instret wraps from 2^64-1 to 0.

## Timing
- Reset values: all outputs 0, state IDLE, cnt 0.
- Reset mid-operation: immediate return to IDLE. No write and no kick are produced for the in-flight instruction.
- Non-load, or load with MEM_READ_LATENCY=0 (MEM_kick_up in cycle T):
  - Reg_write_enable in T+1.
  - WB_kick_up in T+2.
- Load with latency L≥1:
  - Data sampled during cycle T+L.
  - Reg_write_enable in T+L+1.
  - WB_kick_up in T+L+2.
- WB_kick_up is exactly one cycle wide; Reg_write_enable is at most one cycle wide per instruction.
- A new MEM_kick_up is accepted in the same cycle WB_kick_up is high only if it arrives after DONE returns to IDLE, i.e. at earliest the cycle after WB_kick_up.
- instret value is updated at the edge that ends the DONE cycle.

## Test plan
- ADD result: ALU_result=0x0000_1234, regwrite=1, rd=5, kick at T → write x5=0x1234 at T+1, WB_kick_up at T+2, instret=1.
- LB sign extension, L=1: ALU_result=0x103, read data=0x80FF_0000 → x7=0xFFFF_FF80 at T+2, kick at T+3.
- LBU/LHU/LH on the same read word 0x80FF_1234:
  - LHU with off=2 → 0x0000_80FF.
  - LH with off=0 → 0x0000_1234.
  - LBU with off=1 → 0x0000_0012.
- JAL with rd=1, pc_plus_4=0x40 → x1=0x40. Store (regwrite=0) or rd=0 → Reg_write_enable never asserted, but WB_kick_up still pulses and instret increments.
- Latency sweep MEM_READ_LATENCY=0,3 → write at T+1 and T+4 respectively. Read data changing before the sample cycle must not affect the result.
- Robustness:
  - Reset asserted during WAIT → outputs 0, no write, no kick.
  - Extra MEM_kick_up during WAIT → ignored; exactly one retire.
